// File: rtl/uart_fifo_transceiver.sv
// UART transceiver with TX and RX FIFOs, configurable framing.
// RX samples mid-bit after a 2-flop synchroniser; frames keep their error flags.
module uart_fifo_transceiver #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx_in,
  output logic                 uart_tx_out,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  input  logic                 clear_err,
  output logic [CW-1:0]        tx_count,
  output logic [CW-1:0]        rx_count
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int TW   = $clog2(CPB + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int EW   = DATA_BITS + 2;

  localparam logic [TW-1:0] BIT_END  = TW'(CPB - 1);
  localparam logic [TW-1:0] HALF_END = TW'(HALF - 1);
  localparam logic [2:0]    DB_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]    SB_LAST  = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PAR, T_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT
  } rx_state_t;

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]        tx_wp, tx_rp;
  logic                 tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_head_par;

  assign tx_ready    = (tx_count != CW'(FIFO_DEPTH));
  assign tx_push     = tx_valid && tx_ready;
  assign tx_head     = tx_mem[tx_rp];
  assign tx_head_par = (PARITY == 1) ? ~^tx_head : ^tx_head;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
    end
  end

  // TX FSM
  tx_state_t            tx_state, tx_nstate;
  logic [TW-1:0]        tx_tick, tx_ntick;
  logic [2:0]           tx_bit, tx_nbit;
  logic [DATA_BITS-1:0] tx_shift, tx_nshift;
  logic                 tx_par, tx_npar;
  logic                 tx_line;
  logic                 tx_end;

  assign tx_end = (tx_tick == BIT_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state    <= T_IDLE;
      tx_tick     <= '0;
      tx_bit      <= '0;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
      uart_tx_out <= 1'b1;
    end else begin
      tx_state    <= tx_nstate;
      tx_tick     <= tx_ntick;
      tx_bit      <= tx_nbit;
      tx_shift    <= tx_nshift;
      tx_par      <= tx_npar;
      uart_tx_out <= tx_line;
    end
  end

  always_comb begin
    tx_nstate = tx_state;
    tx_ntick  = tx_tick + 1'b1;
    tx_nbit   = tx_bit;
    tx_nshift = tx_shift;
    tx_npar   = tx_par;
    tx_pop    = 1'b0;
    tx_line   = 1'b1;
    unique case (tx_state)
      T_IDLE: begin
        tx_ntick = '0;
        if (tx_count != '0) begin
          tx_pop    = 1'b1;
          tx_nshift = tx_head;
          tx_npar   = tx_head_par;
          tx_nstate = T_START;
        end
      end
      T_START: begin
        tx_line = 1'b0;
        if (tx_end) begin
          tx_ntick  = '0;
          tx_nbit   = '0;
          tx_nstate = T_DATA;
        end
      end
      T_DATA: begin
        tx_line = tx_shift[0];
        if (tx_end) begin
          tx_ntick  = '0;
          tx_nshift = tx_shift >> 1;
          if (tx_bit == DB_LAST) begin
            tx_nbit   = '0;
            tx_nstate = (PARITY != 0) ? T_PAR : T_STOP;
          end else begin
            tx_nbit = tx_bit + 3'd1;
          end
        end
      end
      T_PAR: begin
        tx_line = tx_par;
        if (tx_end) begin
          tx_ntick  = '0;
          tx_nbit   = '0;
          tx_nstate = T_STOP;
        end
      end
      T_STOP: begin
        if (tx_end) begin
          tx_ntick = '0;
          if (tx_bit != SB_LAST) begin
            tx_nbit = tx_bit + 3'd1;
          end else if (tx_count != '0) begin
            // chain straight into the next start bit
            tx_nbit   = '0;
            tx_pop    = 1'b1;
            tx_nshift = tx_head;
            tx_npar   = tx_head_par;
            tx_nstate = T_START;
          end else begin
            tx_nbit   = '0;
            tx_nstate = T_IDLE;
          end
        end
      end
      default: tx_nstate = T_IDLE;
    endcase
  end

  // RX synchroniser and FSM
  logic [1:0] rx_sync;
  logic       rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], uart_rx_in};
  end

  assign rx_s = rx_sync[1];

  rx_state_t            rx_state, rx_nstate;
  logic [TW-1:0]        rx_tick, rx_ntick;
  logic [2:0]           rx_bit, rx_nbit;
  logic [DATA_BITS-1:0] rx_shift, rx_nshift;
  logic                 rx_perr, rx_nperr;
  logic                 rx_fire, rx_exp, rx_end;
  logic                 push_q;
  logic [EW-1:0]        push_word;

  assign rx_end = (rx_tick == BIT_END);
  assign rx_exp = (PARITY == 1) ? ~^rx_shift : ^rx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= R_IDLE;
      rx_tick   <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_perr   <= 1'b0;
      push_q    <= 1'b0;
      push_word <= '0;
    end else begin
      rx_state <= rx_nstate;
      rx_tick  <= rx_ntick;
      rx_bit   <= rx_nbit;
      rx_shift <= rx_nshift;
      rx_perr  <= rx_nperr;
      push_q   <= rx_fire;
      if (rx_fire) push_word <= {~rx_s, rx_perr, rx_shift};
    end
  end

  always_comb begin
    rx_nstate = rx_state;
    rx_ntick  = rx_tick + 1'b1;
    rx_nbit   = rx_bit;
    rx_nshift = rx_shift;
    rx_nperr  = rx_perr;
    rx_fire   = 1'b0;
    unique case (rx_state)
      R_IDLE: begin
        rx_ntick = '0;
        if (!rx_s) rx_nstate = R_START;
      end
      R_START: begin
        if (rx_tick == HALF_END) begin
          rx_ntick  = '0;
          rx_nbit   = '0;
          rx_nstate = rx_s ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (rx_end) begin
          rx_ntick  = '0;
          rx_nshift = {rx_s, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == DB_LAST) begin
            rx_nperr  = 1'b0;
            rx_nstate = (PARITY != 0) ? R_PAR : R_STOP;
          end else begin
            rx_nbit = rx_bit + 3'd1;
          end
        end
      end
      R_PAR: begin
        if (rx_end) begin
          rx_ntick  = '0;
          rx_nperr  = (rx_s != rx_exp);
          rx_nstate = R_STOP;
        end
      end
      R_STOP: begin
        if (rx_end) begin
          rx_ntick  = '0;
          rx_fire   = 1'b1;
          rx_nstate = rx_s ? R_IDLE : R_WAIT;
        end
      end
      R_WAIT: begin
        rx_ntick = '0;
        if (rx_s) rx_nstate = R_IDLE;
      end
      default: rx_nstate = R_IDLE;
    endcase
  end

  // RX FIFO; a full FIFO still accepts a push when it is popped that cycle
  logic [EW-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic          rx_pop, rx_wr, rx_full, rx_drop;

  assign rx_valid = (rx_count != '0);
  assign rx_full  = (rx_count == CW'(FIFO_DEPTH));
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_wr    = push_q && (!rx_full || rx_pop);
  assign rx_drop  = push_q && rx_full && !rx_pop;

  assign {rx_frame_err, rx_parity_err, rx_data} = rx_mem[rx_rp];

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wp] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp      <= '0;
      rx_rp      <= '0;
      rx_count   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_wr)  rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      rx_count <= rx_count + CW'(rx_wr) - CW'(rx_pop);
      if (rx_drop)        rx_overrun <= 1'b1;
      else if (clear_err) rx_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_fifo_transceiver.sv
// Directed bench: 8N1 timing at full baud, 7E1 framing/errors,
// loopback overrun and reset behaviour.
module tb_uart_fifo_transceiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks = 0;
  int fails  = 0;

  // dut0: default parameters
  logic       rx0, tx0, txv0, txr0, rxr0, rpe0, rfe0, rxv0, ovr0, clr0;
  logic [7:0] txd0, rxd0;
  logic [4:0] txc0, rxc0;
  // dut1: 7E1, 16 clocks per bit, depth 4
  logic       rx1, tx1, txv1, txr1, rxr1, rpe1, rfe1, rxv1, ovr1, clr1;
  logic [6:0] txd1, rxd1;
  logic [2:0] txc1, rxc1;
  // dut2: 8N1, 16 clocks per bit, tx looped to rx
  logic       tx2, txv2, txr2, rxr2, rpe2, rfe2, rxv2, ovr2, clr2;
  logic [7:0] txd2, rxd2;
  logic [4:0] txc2, rxc2;

  uart_fifo_transceiver dut0 (
    .clk(clk), .rst_n(rst_n), .uart_rx_in(rx0), .uart_tx_out(tx0),
    .tx_data(txd0), .tx_valid(txv0), .tx_ready(txr0),
    .rx_data(rxd0), .rx_parity_err(rpe0), .rx_frame_err(rfe0),
    .rx_valid(rxv0), .rx_ready(rxr0), .rx_overrun(ovr0),
    .clear_err(clr0), .tx_count(txc0), .rx_count(rxc0)
  );

  uart_fifo_transceiver #(
    .CLK_HZ(16), .BAUD(1), .DATA_BITS(7), .PARITY(2),
    .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .uart_rx_in(rx1), .uart_tx_out(tx1),
    .tx_data(txd1), .tx_valid(txv1), .tx_ready(txr1),
    .rx_data(rxd1), .rx_parity_err(rpe1), .rx_frame_err(rfe1),
    .rx_valid(rxv1), .rx_ready(rxr1), .rx_overrun(ovr1),
    .clear_err(clr1), .tx_count(txc1), .rx_count(rxc1)
  );

  uart_fifo_transceiver #(
    .CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(16)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .uart_rx_in(tx2), .uart_tx_out(tx2),
    .tx_data(txd2), .tx_valid(txv2), .tx_ready(txr2),
    .rx_data(rxd2), .rx_parity_err(rpe2), .rx_frame_err(rfe2),
    .rx_valid(rxv2), .rx_ready(rxr2), .rx_overrun(ovr2),
    .clear_err(clr2), .tx_count(txc2), .rx_count(rxc2)
  );

  typedef struct {
    logic [6:0] data;
    logic       par;
  } tx_vec_t;

  typedef struct {
    logic [6:0] data;
    logic       par;
    logic       stop;
    logic       perr;
    logic       ferr;
  } rx_vec_t;

  tx_vec_t tx_tab [3];
  rx_vec_t rx_tab [6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_serial(input int which, input logic [9:0] bits,
                             input int cpb);
    for (int b = 0; b < 10; b++) begin
      if (which == 0) rx0 = bits[b];
      else            rx1 = bits[b];
      tick(cpb);
    end
  endtask

  logic [9:0] exp_line;
  logic [9:0] got;
  logic [7:0] exp2 [18];
  int bad, to;

  initial begin
    tx_tab[0] = '{7'h41, 1'b0};
    tx_tab[1] = '{7'h7F, 1'b1};
    tx_tab[2] = '{7'h2A, 1'b1};

    rx_tab[0] = '{7'h41, 1'b0, 1'b1, 1'b0, 1'b0};
    rx_tab[1] = '{7'h41, 1'b1, 1'b1, 1'b1, 1'b0};
    rx_tab[2] = '{7'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
    rx_tab[3] = '{7'h2A, 1'b1, 1'b0, 1'b0, 1'b1};
    rx_tab[4] = '{7'h15, 1'b1, 1'b1, 1'b0, 1'b0};
    rx_tab[5] = '{7'h00, 1'b0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 18; i++) exp2[i] = 8'(i * 29 + 5);

    rst_n = 1'b0;
    rx0 = 1'b1; txd0 = '0; txv0 = 0; rxr0 = 0; clr0 = 0;
    rx1 = 1'b1; txd1 = '0; txv1 = 0; rxr1 = 0; clr1 = 0;
    txd2 = '0; txv2 = 0; rxr2 = 0; clr2 = 0;
    tick(3);
    check("reset tx_out", tx0, 1);
    check("reset tx_ready", txr0, 1);
    check("reset rx_valid", rxv0, 0);
    check("reset rx_overrun", ovr0, 0);
    check("reset tx_count", txc0, 0);
    check("reset rx_count", rxc0, 0);
    rst_n = 1'b1;
    tick(5);

    // 0x55 at 868 clocks per bit
    txd0 = 8'h55; txv0 = 1;
    tick(1);
    txv0 = 0;
    check("tx_count after write", txc0, 1);
    check("line idle at write", tx0, 1);
    tick(1);
    check("line idle 1 cycle later", tx0, 1);
    tick(1);
    exp_line = 10'h2AA;
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int c = 0; c < 868; c++) begin
        if (tx0 !== exp_line[k]) bad++;
        tick(1);
      end
      check($sformatf("0x55 bit %0d bad cycles", k), bad, 0);
    end
    check("line high after frame", tx0, 1);
    check("tx_count empty", txc0, 0);

    // short low glitch, then a real frame
    rx0 = 1'b0;
    tick(300);
    rx0 = 1'b1;
    tick(600);
    check("glitch no push", rxc0, 0);
    send_serial(0, {1'b1, 8'hA3, 1'b0}, 868);
    tick(868);
    check("after glitch rx_count", rxc0, 1);
    check("after glitch rx_data", rxd0, 8'hA3);
    check("after glitch flags", {rfe0, rpe0}, 0);
    rxr0 = 1; tick(1); rxr0 = 0;
    check("pop empties rx", rxc0, 0);

    // 7E1 transmit table
    for (int v = 0; v < 3; v++) begin
      txd1 = tx_tab[v].data; txv1 = 1;
      tick(1);
      txv1 = 0;
      to = 0;
      while (tx1 !== 1'b0 && to < 20) begin tick(1); to++; end
      check("7E1 start seen", tx1, 0);
      tick(8);
      for (int b = 0; b < 10; b++) begin
        got[b] = tx1;
        tick(16);
      end
      check($sformatf("7E1 frame %0h", tx_tab[v].data), got,
            {1'b1, tx_tab[v].par, tx_tab[v].data, 1'b0});
    end

    // back-to-back frames with no idle gap
    txd1 = 7'h41; txv1 = 1;
    tick(1);
    txd1 = 7'h7F;
    tick(1);
    txv1 = 0;
    check("tx_count push+pop", txc1, 1);
    to = 0;
    while (tx1 !== 1'b0 && to < 20) begin tick(1); to++; end
    check("b2b first start", tx1, 0);
    tick(159);
    check("b2b last stop cycle", tx1, 1);
    tick(1);
    check("b2b next start", tx1, 0);
    tick(180);

    // 7E1 receive table
    for (int v = 0; v < 6; v++) begin
      send_serial(1, {rx_tab[v].stop, rx_tab[v].par, rx_tab[v].data, 1'b0}, 16);
      if (!rx_tab[v].stop) tick(48);
      rx1 = 1'b1;
      tick(40);
      check($sformatf("rx%0d count", v), rxc1, 1);
      check($sformatf("rx%0d data", v), rxd1, rx_tab[v].data);
      check($sformatf("rx%0d perr", v), rpe1, rx_tab[v].perr);
      check($sformatf("rx%0d ferr", v), rfe1, rx_tab[v].ferr);
      rxr1 = 1; tick(1); rxr1 = 0;
    end

    // loopback: 17 frames into a 16-deep RX FIFO
    for (int i = 0; i < 17; i++) begin
      to = 0;
      while (!txr2 && to < 1000) begin tick(1); to++; end
      txd2 = exp2[i]; txv2 = 1;
      tick(1);
      txv2 = 0;
    end
    to = 0;
    while (txc2 != 0 && to < 4000) begin tick(1); to++; end
    tick(200);
    check("loop rx_count full", rxc2, 16);
    check("loop overrun set", ovr2, 1);
    clr2 = 1;
    tick(1);
    check("clear_err clears", ovr2, 0);
    txd2 = exp2[17]; txv2 = 1;
    tick(1);
    txv2 = 0;
    to = 0;
    while (ovr2 !== 1'b1 && to < 400) begin tick(1); to++; end
    clr2 = 0;
    check("overrun beats clear", ovr2, 1);
    tick(1);
    check("overrun sticky", ovr2, 1);
    clr2 = 1; tick(1); clr2 = 0;
    check("overrun cleared", ovr2, 0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("loop read %0d", i), {rxv2, rxd2}, {1'b1, exp2[i]});
      rxr2 = 1; tick(1); rxr2 = 0;
    end
    check("loop drained", rxc2, 0);

    // reset in the middle of a frame
    txd0 = 8'h00; txv0 = 1;
    tick(1);
    txd0 = 8'hFF;
    tick(1);
    txv0 = 0;
    tick(2000);
    check("mid-frame line low", tx0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async reset tx_out", tx0, 1);
    check("async reset tx_count", txc0, 0);
    check("async reset tx_ready", txr0, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      if (tx0 !== 1'b1) bad++;
      tick(1);
    end
    check("no start after reset", bad, 0);
    check("tx_count stays 0", txc0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
